writeback_arbiter: RTL

Write-back stage of the MIPS datapath, sitting directly upstream of the register file. It arbitrates between the ALU result path and the data-memory load path, one write per cycle, using valid/ready handshakes. It applies load extension and drives the registered write port (Reg_Write, Reg_escrita, Reg_dados). It also generates Counter_Halt, the cycle count until halt that the register file latches into register 24.

---
 rtl/writeback_arbiter_if.sv | 39 +++
 rtl/writeback_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/writeback_arbiter_if.sv
// Handshake and register-file write bus of the MIPS write-back stage.
// master = upstream sources plus register file, slave = writeback_arbiter.
interface writeback_arbiter_if;
    logic        Alu_valid;
    logic        Alu_ready;
    logic [4:0]  Alu_dest;
    logic [31:0] Alu_result;

    logic        Mem_valid;
    logic        Mem_ready;
    logic [4:0]  Mem_dest;
    logic [31:0] Mem_data;
    logic [1:0]  Mem_size;
    logic        Mem_unsigned;
    logic [1:0]  Mem_byte_off;

    logic        Halt;

    logic        Reg_Write;
    logic [4:0]  Reg_escrita;
    logic [31:0] Reg_dados;
    logic [31:0] Counter_Halt;

    modport master (
        output Alu_valid, Alu_dest, Alu_result,
        output Mem_valid, Mem_dest, Mem_data, Mem_size, Mem_unsigned, Mem_byte_off,
        output Halt,
        input  Alu_ready, Mem_ready,
        input  Reg_Write, Reg_escrita, Reg_dados, Counter_Halt
    );

    modport slave (
        input  Alu_valid, Alu_dest, Alu_result,
        input  Mem_valid, Mem_dest, Mem_data, Mem_size, Mem_unsigned, Mem_byte_off,
        input  Halt,
        output Alu_ready, Mem_ready,
        output Reg_Write, Reg_escrita, Reg_dados, Counter_Halt
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: ALU vs load path into the register-file write port, plus halt cycle counter.
// Define WB_LOAD_EXT_EN to enable byte/half lane selection with sign/zero extension of loads.
module writeback_arbiter #(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic                Clock,
    input  logic                Reset,
    writeback_arbiter_if.slave  wb
);

    logic        run;
    logic        force_alu;
    logic        alu_ready;
    logic        mem_ready;
    logic        alu_acc;
    logic        mem_acc;
    logic [31:0] mem_value;

    logic [3:0]  wait_cnt;
    logic        halted;
    logic        reg_write;
    logic [4:0]  reg_escrita;
    logic [31:0] reg_dados;
    logic [31:0] counter_halt;

    assign force_alu = (wait_cnt == 4'(MAX_WAIT));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        run       = 1'b0;
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (Reset && !wb.Halt && !halted) begin
            run = 1'b1;
        end
        if (run) begin
            mem_ready = !force_alu;
            alu_ready = !wb.Mem_valid || force_alu;
        end
    end

    assign alu_acc = wb.Alu_valid && alu_ready;
    assign mem_acc = wb.Mem_valid && mem_ready;

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Little-endian lane select: byte by full offset, half by offset bit 1 only.
    assign load_byte = 8'(wb.Mem_data >> {wb.Mem_byte_off, 3'b000});
    assign load_half = wb.Mem_byte_off[1] ? wb.Mem_data[31:16] : wb.Mem_data[15:0];

    always_comb begin
        mem_value = wb.Mem_data;
        case (wb.Mem_size)
            2'b00:   mem_value = wb.Mem_unsigned ? {24'b0, load_byte}
                                                 : {{24{load_byte[7]}}, load_byte};
            2'b01:   mem_value = wb.Mem_unsigned ? {16'b0, load_half}
                                                 : {{16{load_half[15]}}, load_half};
            default: mem_value = wb.Mem_data;
        endcase
    end
`else
    logic unused_load_ctrl;

    assign unused_load_ctrl = ^{wb.Mem_size, wb.Mem_unsigned, wb.Mem_byte_off};
    assign mem_value        = wb.Mem_data;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            reg_write    <= 1'b0;
            reg_escrita  <= 5'd0;
            reg_dados    <= 32'd0;
            wait_cnt     <= 4'd0;
            halted       <= 1'b0;
            counter_halt <= 32'd0;
        end else begin
            // Writes to r0 still update address/data, only the enable is suppressed.
            if (alu_acc) begin
                reg_write   <= (wb.Alu_dest != 5'd0);
                reg_escrita <= wb.Alu_dest;
                reg_dados   <= wb.Alu_result;
            end else if (mem_acc) begin
                reg_write   <= (wb.Mem_dest != 5'd0);
                reg_escrita <= wb.Mem_dest;
                reg_dados   <= mem_value;
            end else begin
                reg_write   <= 1'b0;
            end

            if (alu_acc || !wb.Alu_valid) begin
                wait_cnt <= 4'd0;
            end else if (mem_acc) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            if (wb.Halt) begin
                halted <= 1'b1;
            end

            if (!halted && !wb.Halt && (counter_halt != 32'hFFFF_FFFF)) begin
                counter_halt <= counter_halt + 32'd1;
            end
        end
    end

    assign wb.Alu_ready    = alu_ready;
    assign wb.Mem_ready    = mem_ready;
    assign wb.Reg_Write    = reg_write;
    assign wb.Reg_escrita  = reg_escrita;
    assign wb.Reg_dados    = reg_dados;
    assign wb.Counter_Halt = counter_halt;

endmodule
